// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer with pipeline stall
module ex_muldiv_ctrl #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   b_r, hi_r, lo_r, spec_r;
    logic              neg_r, special_r;
    logic [CW-1:0]     cnt_r;

    logic              accept;
    logic              sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div0, ovf, special, neg_in;
    logic [XLEN-1:0]   spec_val;

    logic [XLEN:0]     msum, dshift, ddiff;
    logic [XLEN-1:0]   hi_m, lo_m, hi_d, lo_d, hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_val;

    assign accept = (state == IDLE) && start && !kill;

    // Operand conditioning at accept: sign handling, magnitudes and special-case detection
    always_comb begin
        sgn1     = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1     = sgn1 && rs1_data[XLEN-1];
        neg2     = sgn2 && rs2_data[XLEN-1];
        mag1     = neg1 ? -rs1_data : rs1_data;
        mag2     = neg2 ? -rs2_data : rs2_data;
        div0     = funct3[2] && (rs2_data == '0);
        ovf      = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_data);
        special  = div0 || ovf;
        // Remainder follows the dividend sign; product and quotient follow the sign xor
        neg_in   = (funct3[2] && funct3[1]) ? neg1 : (neg1 ^ neg2);
        if (div0)
            spec_val = funct3[1] ? rs1_data : '1;
        else
            spec_val = funct3[1] ? '0 : rs1_data;
    end

    // One shift-add or restoring-divide step on the shared hi/lo accumulator
    always_comb begin
        msum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
        {hi_m, lo_m} = {msum, lo_r[XLEN-1:1]};
        dshift = {hi_r, lo_r[XLEN-1]};
        ddiff  = dshift - {1'b0, b_r};
        hi_d   = ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
        lo_d   = {lo_r[XLEN-2:0], ~ddiff[XLEN]};
        hi_nxt = op_r[2] ? hi_d : hi_m;
        lo_nxt = op_r[2] ? lo_d : lo_m;
        prod_s = neg_r ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        quot_s = neg_r ? -lo_nxt : lo_nxt;
        rem_s  = neg_r ? -hi_nxt : hi_nxt;
        if (special_r)
            final_val = spec_r;
        else if (op_r[2])
            final_val = op_r[1] ? rem_s : quot_s;
        else if (op_r[1:0] == 2'b00)
            final_val = prod_s[XLEN-1:0];
        else
            final_val = prod_s[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; kill aborts from any state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (special && FAST_SPECIAL) ? DONE : CALC;
            CALC: if (kill) state_nxt = IDLE;
                  else if (cnt_r == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs; stall is held low during reset
    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        stall = !rst && (busy || accept);
    end

    // Datapath: latch operands at accept, iterate in CALC, write result on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= '0;
            b_r       <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            spec_r    <= '0;
            neg_r     <= 1'b0;
            special_r <= 1'b0;
            cnt_r     <= '0;
            result    <= '0;
        end else if (accept) begin
            op_r      <= funct3;
            b_r       <= funct3[2] ? mag2 : mag1;
            hi_r      <= '0;
            lo_r      <= funct3[2] ? mag1 : mag2;
            spec_r    <= spec_val;
            neg_r     <= neg_in;
            special_r <= special;
            cnt_r     <= CW'(XLEN - 1);
            if (special && FAST_SPECIAL)
                result <= spec_val;
        end else if (state == CALC && !kill) begin
            hi_r <= hi_nxt;
            lo_r <= lo_nxt;
            if (cnt_r == '0)
                result <= final_val;
            else
                cnt_r <= cnt_r - 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - directed self-checking bench for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        busy0, stall0, done0, busy1, stall1, done1;
    logic [31:0] result0, result1;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    ex_muldiv_ctrl #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .kill(kill), .busy(busy0), .stall(stall0), .done(done0), .result(result0));

    ex_muldiv_ctrl #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .kill(kill), .busy(busy1), .stall(stall1), .done(done1), .result(result1));

    always #5 clk = ~clk;

    // Issue one op at the current negedge and watch both instances for 40 cycles
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat0, input int lat1, input bit hold);
        int c0 = 0, c1 = 0, d0 = 0, d1 = 0, bad0 = 0, bad1 = 0;
        logic [31:0] r0 = '0, r1 = '0;
        funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
        #1;
        total_cnt++;
        if (stall0 !== 1'b1 || stall1 !== 1'b1) $display("FAIL %s stall_at_start: got %b/%b want 1", name, stall0, stall1);
        else pass_cnt++;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        rs1_data = 32'h5A5A_1234; rs2_data = 32'h0000_0003; funct3 = f3 ^ 3'b101;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy0 !== (n <= lat0)) bad0++;
            if (busy1 !== (n <= lat1)) bad1++;
            if (done0) begin c0++; d0 = n; r0 = result0; end
            if (done1) begin c1++; d1 = n; r1 = result1; end
            if (hold && done0) start = 1'b0;
        end
        total_cnt++;
        if (c0 != 1 || d0 != lat0) $display("FAIL %s fast_done: count %0d at %0d, want 1 at %0d", name, c0, d0, lat0);
        else pass_cnt++;
        total_cnt++;
        if (r0 !== exp) $display("FAIL %s fast_result: got %h want %h", name, r0, exp);
        else pass_cnt++;
        total_cnt++;
        if (c1 != 1 || d1 != lat1) $display("FAIL %s slow_done: count %0d at %0d, want 1 at %0d", name, c1, d1, lat1);
        else pass_cnt++;
        total_cnt++;
        if (r1 !== exp) $display("FAIL %s slow_result: got %h want %h", name, r1, exp);
        else pass_cnt++;
        total_cnt++;
        if (bad0 != 0 || bad1 != 0) $display("FAIL %s busy_profile: %0d/%0d bad cycles want 0", name, bad0, bad1);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(negedge clk);
        start = 1'b1; #1;
        total_cnt++;
        if (stall0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 32'h0)
            $display("FAIL reset_state: stall=%b busy=%b done=%b result=%h want 0", stall0, busy0, done0, result0);
        else pass_cnt++;
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,       33, 33, 1'b0);
        run_op("mul_neg",     3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33, 33, 1'b0);
        run_op("mulh_m1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 33, 1'b0);
        run_op("mulhu_m1",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33, 1'b0);
        run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 33, 1'b0);
    endtask

    task automatic test_div();
        run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33, 1'b0);
        run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33, 1'b0);
        run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33, 33, 1'b0);
        run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33, 33, 1'b0);
    endtask

    task automatic test_special();
        run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 33, 1'b0);
        run_op("remu_by0",    3'b111, 32'd5,        32'd0,        32'd5,        1, 33, 1'b0);
        run_op("div_neg_by0", 3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, 33, 1'b0);
        run_op("rem_neg_by0", 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 33, 1'b0);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33, 1'b0);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 33, 1'b0);
    endtask

    task automatic test_kill();
        logic [31:0] keep0, keep1;
        int seen = 0;
        keep0 = result0; keep1 = result1;
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        kill = 1'b1; start = 1'b1; #1;
        total_cnt++;
        if (stall0 !== 1'b1) $display("FAIL kill_stall_busy: got %b want 1", stall0);
        else pass_cnt++;
        start = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        if (done0 || done1) seen++;
        total_cnt++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || seen != 0)
            $display("FAIL kill_abort: busy=%b/%b dones=%0d want 0/0/0", busy0, busy1, seen);
        else pass_cnt++;
        total_cnt++;
        if (result0 !== keep0 || result1 !== keep1)
            $display("FAIL kill_result_hold: got %h/%h want %h/%h", result0, result1, keep0, keep1);
        else pass_cnt++;
        run_op("after_kill", 3'b000, 32'd9, 32'd11, 32'd99, 33, 33, 1'b0);
        kill = 1'b1; start = 1'b1; #1;
        total_cnt++;
        if (stall0 !== 1'b0 || stall1 !== 1'b0) $display("FAIL kill_blocks_start: stall=%b/%b want 0", stall0, stall1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL kill_start_ignored: busy=%b/%b want 0", busy0, busy1);
        else pass_cnt++;
        kill = 1'b0; start = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op("held_start",  3'b011, 32'd3,        32'd4,        32'd0,        33, 33, 1'b1);
        run_op("next_issue",  3'b000, 32'd1000,     32'd1000,     32'd1000000,  33, 33, 1'b0);
    endtask

    task automatic test_rst_mid();
        funct3 = 3'b000; rs1_data = 32'd8; rs2_data = 32'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1; #1;
        total_cnt++;
        if (stall0 !== 1'b0 || stall1 !== 1'b0) $display("FAIL rst_stall: got %b/%b want 0", stall0, stall1);
        else pass_cnt++;
        start = 1'b0;
        total_cnt++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 32'h0 || busy1 !== 1'b0 || result1 !== 32'h0)
            $display("FAIL rst_mid_op: busy=%b done=%b result=%h/%h want 0", busy0, done0, result0, result1);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 33, 33, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
